// File: rtl/sd_data_fifo.sv
// Circular-buffer data FIFO with first-word fall-through read port and packed APB status word.
// Optional sticky overflow/underflow flags are built when SD_FIFO_ERR_FLAGS_EN is defined.
module sd_data_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             enq_i,
    input  logic             deq_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             flush_i,
    input  logic             clr_flags_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [4:0]       count_o,
    output logic [15:0]      status_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [4:0]       r_count;

    logic w_full;
    logic w_empty;
    logic w_enq_ok;
    logic w_deq_ok;
    logic w_ovf_flag;
    logic w_unf_flag;

    assign w_full   = (r_count == 5'(DEPTH));
    assign w_empty  = (r_count == 5'd0);
    // A full FIFO still takes a write when a read frees the head slot in the same cycle.
    assign w_enq_ok = enq_i && (!w_full || deq_i);
    assign w_deq_ok = deq_i && !w_empty;

    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (preset || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_enq_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq_ok, w_deq_ok})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge pclk) begin
        if (!preset && !flush_i && w_enq_ok) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

`ifdef SD_FIFO_ERR_FLAGS_EN
    logic r_ovf_flag;
    logic r_unf_flag;
    logic w_ovf_evt;
    logic w_unf_evt;

    assign w_ovf_evt = !flush_i && enq_i && w_full && !deq_i;
    assign w_unf_evt = !flush_i && deq_i && w_empty;

    // A set event outranks a same-cycle clear so no error is ever lost.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_ovf_flag <= 1'b0;
            r_unf_flag <= 1'b0;
        end else begin
            if (w_ovf_evt)        r_ovf_flag <= 1'b1;
            else if (clr_flags_i) r_ovf_flag <= 1'b0;
            if (w_unf_evt)        r_unf_flag <= 1'b1;
            else if (clr_flags_i) r_unf_flag <= 1'b0;
        end
    end

    assign w_ovf_flag = r_ovf_flag;
    assign w_unf_flag = r_unf_flag;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_flags_i;
    assign w_ovf_flag   = 1'b0;
    assign w_unf_flag   = 1'b0;
`endif

    assign rd_data_o = w_empty ? WIDTH'(16'h00FF) : r_mem[r_rd_ptr];
    assign full_o    = w_full;
    assign empty_o   = w_empty;
    assign count_o   = r_count;
    assign status_o  = {w_full, w_empty, w_ovf_flag, w_unf_flag, 7'b0, r_count};

endmodule

// File: tb/tb_sd_data_fifo.sv
// Directed self-checking bench for sd_data_fifo; expectations follow the flag build option.
module tb_sd_data_fifo;

`ifdef SD_FIFO_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif
    localparam logic [15:0] OVF = FLAGS ? 16'h2000 : 16'h0000;
    localparam logic [15:0] UNF = FLAGS ? 16'h1000 : 16'h0000;

    logic        pclk = 1'b0;
    logic        preset, enq_i, deq_i, flush_i, clr_flags_i;
    logic [15:0] wr_data_i;
    logic [15:0] rd_data_o;
    logic        full_o, empty_o;
    logic [4:0]  count_o;
    logic [15:0] status_o;

    int n_checks = 0;
    int n_fail   = 0;

    sd_data_fifo #(.DEPTH(8), .WIDTH(16)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .enq_i       (enq_i),
        .deq_i       (deq_i),
        .wr_data_i   (wr_data_i),
        .flush_i     (flush_i),
        .clr_flags_i (clr_flags_i),
        .rd_data_o   (rd_data_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .status_o    (status_o)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then return 1 ns after the edge with strobes idle.
    task automatic cycle(input logic enq, input logic deq, input logic [15:0] data,
                         input logic flush, input logic clr, input logic rst);
        enq_i       = enq;
        deq_i       = deq;
        wr_data_i   = data;
        flush_i     = flush;
        clr_flags_i = clr;
        preset      = rst;
        @(posedge pclk);
        #1;
        enq_i = 1'b0; deq_i = 1'b0; flush_i = 1'b0; clr_flags_i = 1'b0; preset = 1'b0;
        wr_data_i = 16'h0000;
    endtask

    initial begin
        preset = 1'b1; enq_i = 1'b0; deq_i = 1'b0; flush_i = 1'b0; clr_flags_i = 1'b0;
        wr_data_i = 16'h0000;
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_rd", 32'(rd_data_o), 32'h00FF);
        check("rst_status", 32'(status_o), 32'h4000);

        // Basic FWFT ordering
        cycle(1'b1, 1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        check("fwft_rd", 32'(rd_data_o), 32'hA5A5);
        check("fwft_count", 32'(count_o), 32'd1);
        cycle(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
        check("two_count", 32'(count_o), 32'd2);
        check("two_rd", 32'(rd_data_o), 32'hA5A5);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("deq1_rd", 32'(rd_data_o), 32'h1234);
        check("deq1_count", 32'(count_o), 32'd1);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("deq2_empty", 32'(empty_o), 32'd1);
        check("deq2_rd", 32'(rd_data_o), 32'h00FF);

        // Fill, then overflow attempt
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0, 1'b0, 1'b0);
        check("fill_full", 32'(full_o), 32'd1);
        check("fill_count", 32'(count_o), 32'd8);
        cycle(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        check("ovf_count", 32'(count_o), 32'd8);
        check("ovf_status", 32'(status_o), 32'(16'h8008 | OVF));
        check("ovf_rd", 32'(rd_data_o), 32'h0000);

        // Simultaneous enq/deq while full, then drain across the wrap
        cycle(1'b1, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
        check("fullrw_count", 32'(count_o), 32'd8);
        check("fullrw_full", 32'(full_o), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_%0d", i), 32'(rd_data_o), 32'(i));
            cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        end
        check("drain_empty", 32'(empty_o), 32'd1);
        check("drain_status", 32'(status_o), 32'(16'h4000 | OVF));

        // Underflow flag, clear, set-beats-clear
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check("clr_ovf", 32'(status_o), 32'h4000);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("unf_status", 32'(status_o), 32'(16'h4000 | UNF));
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check("clr_unf", 32'(status_o), 32'h4000);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        check("set_wins", 32'(status_o), 32'(16'h4000 | UNF));
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Empty with enq and deq together: enqueue only, underflow raised
        cycle(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
        check("erw_count", 32'(count_o), 32'd1);
        check("erw_rd", 32'(rd_data_o), 32'h0077);
        check("erw_status", 32'(status_o), 32'(16'h0001 | UNF));
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Flush overrides enq and keeps sticky flags
        cycle(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0202, 1'b0, 1'b0, 1'b0);
        check("pre_flush_count", 32'(count_o), 32'd3);
        cycle(1'b1, 1'b1, 16'h0303, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("unf_again", 32'(status_o), 32'(16'h4000 | UNF));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'(16'h0010 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        check("flush_count", 32'(count_o), 32'd0);
        check("flush_empty", 32'(empty_o), 32'd1);
        check("flush_rd", 32'(rd_data_o), 32'h00FF);
        check("flush_flags", 32'(status_o), 32'(16'h4000 | UNF));

        // Reset mid-operation overrides enq and clears flags
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'(16'h0020 + i), 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count_o), 32'd3);
        cycle(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        check("mrst_count", 32'(count_o), 32'd0);
        check("mrst_empty", 32'(empty_o), 32'd1);
        check("mrst_full", 32'(full_o), 32'd0);
        check("mrst_rd", 32'(rd_data_o), 32'h00FF);
        check("mrst_status", 32'(status_o), 32'h4000);
        cycle(1'b1, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0);
        check("post_rst_rd", 32'(rd_data_o), 32'h0042);
        check("post_rst_count", 32'(count_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_data_fifo.md
SD_DATA_FIFO -- requirements
Module: sd_data_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of 16-bit entries; power of two, 2..16 only.
REQ-002 SHALL provide parameter WIDTH, default 16, entry width in bits; fixed at 16 for APB use.
REQ-003 SHALL have port pclk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port preset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enq_i  input  1  enqueue strobe (connects to st_buf_enq or SPI-side write).
REQ-006 SHALL have port deq_i  input  1  dequeue strobe (connects to ld_buf_deq or SPI-side read).
REQ-007 SHALL have port wr_data_i  input  WIDTH  data written on enqueue.
REQ-008 SHALL have port flush_i  input  1  synchronous clear of contents.
REQ-009 SHALL have port clr_flags_i  input  1  clears sticky error flags.
REQ-010 SHALL have port rd_data_o  output  WIDTH  head entry, first-word fall-through.
REQ-011 SHALL have port full_o  output  1  count == DEPTH.
REQ-012 SHALL have port empty_o  output  1  count == 0.
REQ-013 SHALL have port count_o  output  5  current occupancy, 0..DEPTH.
REQ-014 SHALL have port status_o  output  16  packed status word for the APB status register.

Function
REQ-015 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-016 rd_data_o SHALL show the entry at the read pointer combinationally when not empty; 16'h00FF when empty.
REQ-017 Enqueue accepted when enq_i and (not full or deq_i): entry written, write pointer advances; data visible on rd_data_o the next cycle if FIFO was empty.
REQ-018 Dequeue accepted when deq_i and not empty: read pointer advances; next entry visible the following cycle.
REQ-019 Count SHALL increment on accepted enqueue only, decrement on accepted dequeue only, and hold when both or neither are accepted.
REQ-020 Full plus enq_i plus deq_i: both accepted, count stays DEPTH, no overflow.
REQ-021 Empty plus enq_i plus deq_i: enqueue accepted, dequeue ignored, count becomes 1, underflow event raised.
REQ-022 enq_i while full without deq_i SHALL be dropped: contents, pointers and count unchanged.
REQ-023 deq_i while empty SHALL be ignored: contents, pointers and count unchanged.
REQ-024 flush_i SHALL set pointers and count to 0 next cycle, override same-cycle enq_i/deq_i, and leave sticky flags unchanged.
REQ-025 status_o SHALL pack [15]=full_o, [14]=empty_o, [13]=overflow flag, [12]=underflow flag, [11:5]=0, [4:0]=count_o.

Reset
REQ-026 On preset high at a clock edge: pointers=0, count_o=0, empty_o=1, full_o=0, flags=0, rd_data_o=16'h00FF; preset SHALL override all other inputs.
REQ-027 Reset mid-operation SHALL discard all entries; storage array contents need not be cleared.

Configuration
REQ-028 With macro SD_FIFO_ERR_FLAGS_EN defined: overflow flag set by REQ-022 events and underflow flag set by REQ-021/REQ-023 events; both sticky until clr_flags_i or reset; a set event in the same cycle as clr_flags_i SHALL win.
REQ-029 With SD_FIFO_ERR_FLAGS_EN undefined: no flag registers; status_o[13:12] tied 0; clr_flags_i ignored.

Verification
REQ-030 Reset, then enq 16'hA5A5, 16'h1234 -> count_o=2, rd_data_o=16'hA5A5 the cycle after first enq; deq -> 16'h1234.
REQ-031 Fill DEPTH=8 with 0..7, then enq 16'hDEAD -> dropped, full_o=1, status_o=16'hA008 (flags enabled).
REQ-032 Full, then enq 16'h0008 and deq same cycle -> count stays 8; drain yields 1..7 then 16'h0008, confirming wrap.
REQ-033 Empty, deq alone -> status_o=16'h5000; then clr_flags_i -> status_o=16'h4000.
REQ-034 Three entries, assert flush_i with enq_i -> count_o=0, empty_o=1, rd_data_o=16'h00FF next cycle.
REQ-035 Three entries, assert preset for one cycle -> all outputs at REQ-026 values; subsequent enq 16'h0042 -> rd_data_o=16'h0042.
